// File: rtl/bcd_display_sched_pkg.sv
// bcd_disp_pkg: FSM encoding, active-low seven-segment patterns and decimal range helper.
package bcd_disp_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction
endpackage

// File: rtl/bcd_display_sched_if.sv
// bcd_display_sched_if: value-source side of the display controller.
//   bin_in/load  source -> controller: value and single-cycle start request
//   busy/done/overflow  controller -> source: conversion status
interface bcd_display_sched_if #(parameter int BIN_W = 14);
  logic [BIN_W-1:0] bin_in;
  logic load;
  logic busy;
  logic done;
  logic overflow;
  modport master (output bin_in, load, input busy, done, overflow);
  modport slave (input bin_in, load, output busy, done, overflow);
endinterface

// File: rtl/bcd_display_sched_seg7.sv
// bcd_to_seg7: BCD digit to active-low seven-segment pattern (seg[0]=a .. seg[6]=g).
//   digit  in  4  BCD value; 10..15 show blank
//   blank  in  1  force all segments off
//   seg    out 7  active-low segment pattern
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank)
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/bcd_display_sched.sv
// bcd_display_sched: double-dabble conversion of a loaded value, scanned onto a
// common-anode seven-segment display.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side: bin_in/load in, busy/done/overflow out
//   an          active-low anode enables, one digit at a time
//   seg         active-low segments of the selected digit
module bcd_display_sched
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int DIGITS = 4,
  parameter int TICK_DIV = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_display_sched_if.slave bus,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);
  localparam int DW = DIGITS * 4;
  localparam int SW = DW + BIN_W;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX = max_dec(DIGITS);
  state_t state, state_n;
  logic [SW-1:0] sc, adj;
  logic [CW-1:0] iter;
  logic [DW-1:0] disp, disp_n;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] idx, idx_n;
  logic [3:0] dig;
  logic [6:0] seg_n;
  logic busy, done, ovf, tick, blank, cap, step, lat;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.overflow = ovf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (bus.load ? CONVERT : IDLE) :
              state == CONVERT ? (iter == CW'(BIN_W - 1) ? LATCH : CONVERT) : IDLE;
  always_comb begin
    cap = state == IDLE && bus.load;
    step = state == CONVERT;
    lat = state == LATCH;
  end
  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  always_comb begin
    adj = sc;
    for (int i = 0; i < DIGITS; i++)
      adj[BIN_W+4*i +: 4] = sc[BIN_W+4*i +: 4] + (sc[BIN_W+4*i +: 4] >= 4'd5 ? 4'd3 : 4'd0);
  end
  assign disp_n = lat ? (ovf ? {DIGITS{4'd9}} : sc[SW-1:BIN_W]) : disp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      sc <= '0;
      iter <= '0;
      disp <= '0;
    end else begin
      busy <= state_n != IDLE;
      done <= lat;
      disp <= disp_n;
      if (cap) begin
        sc <= SW'(bus.bin_in);
        iter <= '0;
        ovf <= 64'(bus.bin_in) > MAX;
      end
      if (step) begin
        sc <= adj << 1;
        iter <= iter + 1'b1;
      end
    end
  assign tick = tcnt == TW'(TICK_DIV - 1);
  assign idx_n = tick ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
  // an/seg are registered from next-cycle index and display so they stay aligned with idx.
  always_comb begin
    dig = '0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_n == IW'(i)) begin
        dig = disp_n[4*i +: 4];
        blank = BLANK_LEADING != 0 && i != 0 && (disp_n >> (4 * i)) == '0;
      end
  end
  bcd_to_seg7 u_seg7 (.digit(dig), .blank(blank), .seg(seg_n));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      idx <= '0;
      an <= ~DIGITS'(1);
      seg <= SEG_0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      idx <= idx_n;
      an <= ~(DIGITS'(1) << idx_n);
      seg <= seg_n;
    end
endmodule

// File: tb/tb_bcd_display_sched.sv
`timescale 1ns/1ps
module tb_bcd_display_sched;
  localparam int BIN_W = 14;
  localparam int DIGITS = 4;
  localparam int TICK_DIV = 4;
  localparam int LAT = BIN_W + 1;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  typedef struct packed {
    logic [3:0][6:0] seg;
    logic ovf;
    int lc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DIGITS-1:0] an;
  logic [6:0] seg;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  exp_t cur;
  int scan_left = 0;
  int brun = 0;
  int run = 0;
  logic run_ok = 1'b0;
  logic [3:0] prev_an = 4'b1110;
  bcd_display_sched_if #(.BIN_W(BIN_W)) bus();
  bcd_display_sched #(.BIN_W(BIN_W), .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .an(an), .seg(seg));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Monitor: pops an expectation on every done pulse and checks the scanned digits.
  always @(negedge clk) begin
    if (!rst_n) begin
      scan_left = 0;
      brun = 0;
      run = 0;
      run_ok = 1'b0;
      prev_an = an;
    end else begin
      if (bus.done) begin
        if (q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          cur = q.pop_front();
          chk("overflow", {31'd0, bus.overflow}, {31'd0, cur.ovf});
          chk("done_latency", cyc - cur.lc, LAT);
          scan_left = DIGITS * TICK_DIV;
        end
      end
      if (scan_left > 0) begin
        scan_left--;
        case (an)
          4'b1110: chk("seg_d0", {25'd0, seg}, {25'd0, cur.seg[0]});
          4'b1101: chk("seg_d1", {25'd0, seg}, {25'd0, cur.seg[1]});
          4'b1011: chk("seg_d2", {25'd0, seg}, {25'd0, cur.seg[2]});
          4'b0111: chk("seg_d3", {25'd0, seg}, {25'd0, cur.seg[3]});
          default: chk("an_onehot", {28'd0, an}, 32'he);
        endcase
      end
      if (bus.busy) brun++;
      else if (brun != 0) begin
        chk("busy_len", brun, LAT);
        brun = 0;
      end
      if (an != prev_an) begin
        if (run_ok) begin
          chk("scan_dwell", run, TICK_DIV);
          chk("scan_order", {28'd0, an}, {28'd0, prev_an[2:0], prev_an[3]});
        end
        run_ok = 1'b1;
        run = 1;
      end else run++;
      prev_an = an;
    end
  end
  task automatic ld(input int v, input logic push, input logic [3:0][6:0] s, input logic o);
    @(negedge clk);
    bus.bin_in = v[BIN_W-1:0];
    bus.load = 1'b1;
    if (push) q.push_back(exp_t'{seg: s, ovf: o, lc: cyc + 1});
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, bus.done}, 1);
    repeat (DIGITS * TICK_DIV + 2) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_an"}, {28'd0, an}, 32'he);
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, S0});
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, "_done"}, {31'd0, bus.done}, 0);
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.bin_in = '0;
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    ld(1234, 1, {S1, S2, S3, S4}, 1'b0);
    wait_done();
    ld(12000, 1, {S9, S9, S9, S9}, 1'b1);
    wait_done();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ld(1234, 1, {S1, S2, S3, S4}, 1'b0);
    repeat (1) @(negedge clk);
    ld(5, 0, '0, 1'b0);
    wait_done();
    ld(7, 1, {SB, SB, SB, S7}, 1'b0);
    wait_done();
    ld(1007, 1, {S1, S0, S0, S7}, 1'b0);
    wait_done();
    ld(1234, 0, '0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ld(42, 1, {SB, SB, S4, S2}, 1'b0);
    wait_done();
    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
